// File: rtl/seg_pkg.sv
// Shared constants and helpers for the six-digit multiplexed 7-segment display.
// Segment codes are active-low with bit 7 = dp, bits 6..0 = g..a.
package seg_pkg;

  localparam int DIGITS = 6;
  localparam logic [19:0] DATA_MAX = 20'd999_999;

  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;

  function automatic logic [7:0] hex2seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before a shift.
  function automatic logic [23:0] add3(input logic [23:0] b);
    logic [23:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3
                                          : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential shift-add-3 converter: latch, 20 shift cycles, commit cycle.
// Input is clamped to 999_999; result is valid while done is high.
module bin2bcd
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] result
);

  conv_state_t state;
  logic [19:0] sh;
  logic [23:0] work;
  logic [4:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CONV_IDLE;
      sh    <= '0;
      work  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            sh    <= (bin > DATA_MAX) ? DATA_MAX : bin;
            work  <= '0;
            cnt   <= '0;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {work, sh} <= {add3(work), sh} << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd19) state <= CONV_COMMIT;
        end
        CONV_COMMIT: state <= CONV_IDLE;
        default:     state <= CONV_IDLE;
      endcase
    end
  end

  assign busy   = (state != CONV_IDLE);
  assign done   = (state == CONV_COMMIT);
  assign result = work;

endmodule

// File: rtl/seg_dynamic.sv
// Six-digit multiplexed 7-segment driver with continuous binary-to-BCD refresh.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg_dynamic
  import seg_pkg::*;
#(
  parameter int CNT_MAX = 24_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  input  logic        sign,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [CW-1:0]    cnt;
  logic [2:0]       idx;
  logic [23:0]      bcd;
  logic [5:0][3:0]  digits;
  logic             busy;
  logic             done;
  logic [23:0]      result;
  logic [7:0]       code;

  bin2bcd u_conv (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .start  (!busy),
    .bin    (data),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Only whole conversions reach the display.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)   bcd <= '0;
    else if (done) bcd <= result;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(CNT_MAX - 1)) begin
      cnt <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign digits = bcd;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [2:0] msd;

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if (digits[i] != 4'd0) msd = 3'(i);
    end
  end

  // Minus sits just left of the MSD; with MSD in digit 5 it never matches.
  always_comb begin
    code = SEG_BLANK;
    if (idx <= msd)                    code = hex2seg(digits[idx]);
    else if (sign && idx == msd + 3'd1) code = SEG_MINUS;
  end
`else
  always_comb begin
    code = hex2seg(digits[idx]);
    if (sign && idx == 3'd5) code = SEG_MINUS;
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      sel <= ~(6'b1 << idx);
      seg <= {code[7] & ~point[idx], code[6:0]};
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
// Scoreboard bench for seg_dynamic with CNT_MAX=4.
// Honours SEG_LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seg_dynamic;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic [5:0]  sel;
  logic [7:0]  seg;

  seg_dynamic #(.CNT_MAX(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .en      (en),
    .sign    (sign),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    bit         first;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // segs = {d5,d4,d3,d2,d1,d0}; one scan in order digit 0..5.
  task automatic push6(input logic [47:0] segs);
    logic [5:0] s;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      s = 6'h3F;
      s[i] = 1'b0;
      e.sel = s;
      e.seg = segs[i*8 +: 8];
      e.first = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge sys_clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d slots not seen, required 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  task automatic settle();
    repeat (50) @(posedge sys_clk);
  endtask

  // Monitor: a new slot begins whenever sel changes to a lit digit.
  logic [5:0] prev_sel = 6'h3F;
  int         cyc = 0;
  int         last_chg = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (sel !== prev_sel) begin
      if (sel != 6'h3F && sb.size() > 0) begin
        if (sb[0].first) begin
          if (sel == sb[0].sel) begin
            chk("seg_digit0", 32'(seg), 32'(sb[0].seg));
            void'(sb.pop_front());
          end
        end else begin
          chk("sel_order", 32'(sel), 32'(sb[0].sel));
          chk("seg_digit", 32'(seg), 32'(sb[0].seg));
          chk("slot_len", 32'(cyc - last_chg), 32'd4);
          void'(sb.pop_front());
        end
      end
      last_chg = cyc;
      prev_sel = sel;
    end
  end

  initial begin
    sys_rst = 1'b1;
    data    = 20'd0;
    point   = 6'd0;
    en      = 1'b1;
    sign    = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_sel", 32'(sel), 32'h3F);
    chk("rst_seg", 32'(seg), 32'hFF);
    sys_rst = 1'b0;

    // value 0
    settle();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push6({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
`else
    push6({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
`endif
    wait_drain("zero");

    // 123456 with dp on digit 2
    @(negedge sys_clk);
    data  = 20'd123_456;
    point = 6'b000100;
    settle();
    push6({8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82});
    wait_drain("dp");

    // sign with MSD in digit 5
    @(negedge sys_clk);
    point = 6'd0;
    sign  = 1'b1;
    settle();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push6({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
`else
    push6({8'hBF, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
`endif
    wait_drain("sign_full");

    // clamp
    @(negedge sys_clk);
    sign = 1'b0;
    data = 20'd1_000_000;
    settle();
    push6({8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
    wait_drain("clamp");

    // 42 negative
    @(negedge sys_clk);
    data = 20'd42;
    sign = 1'b1;
    settle();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push6({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
`else
    push6({8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hA4});
`endif
    wait_drain("neg42");

    // enable dropped mid-slot, then restored
    for (int i = 0; i < 100 && sel != 6'h37; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    en = 1'b0;
    tick();
    chk("en_off_sel", 32'(sel), 32'h3F);
    chk("en_off_seg", 32'(seg), 32'hFF);
    repeat (3) tick();
    chk("en_hold_sel", 32'(sel), 32'h3F);
    @(negedge sys_clk);
    en = 1'b1;
    tick();
    chk("en_on_sel", 32'(sel), 32'h3E);
    chk("en_on_seg", 32'(seg), 32'hA4);
    repeat (4) tick();
    chk("en_next_sel", 32'(sel), 32'h3D);

    // reset mid-conversion after 7 -> 8
    @(negedge sys_clk);
    data = 20'd7;
    sign = 1'b0;
    settle();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push6({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});
`else
    push6({8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8});
`endif
    wait_drain("seven");
    @(negedge sys_clk);
    data = 20'd8;
    repeat (5) tick();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick();
    chk("mid_rst_sel", 32'(sel), 32'h3F);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_bcd", 32'(dut.bcd), 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        chk("post_rst_sel", 32'(sel), 32'h3E);
        chk("post_rst_seg", 32'(seg), 32'hC0);
      end
      if (i == 21) chk("bcd_before_22", 32'(dut.bcd), 32'h0);
      if (i == 22) chk("bcd_at_22", 32'(dut.bcd), 32'h8);
      if (i == 25) begin
        chk("eight_sel", 32'(sel), 32'h3E);
        chk("eight_seg", 32'(seg), 32'h80);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
